lut_layer_sequencer: RTL and testbench

Time-multiplexed evaluator for one LogicNets LUT layer. Rather than instantiating one hard-coded truth-table module per neuron, it holds all neuron truth tables in a shared, runtime-loadable memory and evaluates the neurons one per cycle. For each neuron it gathers that neuron's fan-in features from a captured input activation vector, looks up the neuron's output code, and assembles the full output vector. It sits between two layer pipeline stages, with valid/ready on both sides and a configuration write port for tables and fan-in maps.

---
 rtl/lut_layer_sequencer_if.sv | 35 +++
 rtl/lut_layer_sequencer.sv | 110 +++++++++++
 tb/tb_lut_layer_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_sequencer_if.sv
// Handshake and configuration bundle for lut_layer_sequencer.
// master = surrounding pipeline / config host, slave = the sequencer.
interface lut_layer_sequencer_if #(
   parameter int NEURONS  = 16,
   parameter int IN_WIDTH = 32,
   parameter int IN_BITS  = 2,
   parameter int FANIN    = 4,
   parameter int OUT_BITS = 2
);
   localparam int A  = FANIN*IN_BITS;
   localparam int NW = $clog2(NEURONS);
   localparam int IW = $clog2(IN_WIDTH);
   localparam int CW = (OUT_BITS > IW) ? OUT_BITS : IW;

   logic                         s_valid;
   logic                         s_ready;
   logic [IN_WIDTH*IN_BITS-1:0]  s_data;
   logic                         m_valid;
   logic                         m_ready;
   logic [NEURONS*OUT_BITS-1:0]  m_data;
   logic                         cfg_we;
   logic                         cfg_sel;
   logic [NW+A-1:0]              cfg_addr;
   logic [CW-1:0]                cfg_wdata;
   logic                         cfg_ready;

   modport master (
      output s_valid, s_data, m_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
      input  s_ready, m_valid, m_data, cfg_ready
   );
   modport slave (
      input  s_valid, s_data, m_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
      output s_ready, m_valid, m_data, cfg_ready
   );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets LUT layer: one neuron per cycle through a shared,
// runtime-loadable truth-table memory, gathering fan-in via a per-neuron map.
module lut_layer_sequencer #(
   parameter int NEURONS  = 16,
   parameter int IN_WIDTH = 32,
   parameter int IN_BITS  = 2,
   parameter int FANIN    = 4,
   parameter int OUT_BITS = 2
) (
   input logic                  clk,
   input logic                  rst,
   lut_layer_sequencer_if.slave bus
);
   localparam int A     = FANIN*IN_BITS;
   localparam int NW    = $clog2(NEURONS);
   localparam int IW    = $clog2(IN_WIDTH);
   localparam int KW    = (FANIN > 1) ? $clog2(FANIN) : 1;
   localparam int DEPTH = NEURONS << A;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [NW-1:0]               idx, idx_d;
   logic [IN_WIDTH*IN_BITS-1:0] in_reg;
   logic [IN_BITS-1:0]          feat [2**IW];
   logic [IW-1:0]               fmap [NEURONS][FANIN];
   logic [OUT_BITS-1:0]         tbl  [DEPTH];
   logic [A-1:0]                addr;
   logic [OUT_BITS-1:0]         rd_data;
   logic                        rd_en, rd_vld, idle, accept, cfg_ok;

   // Feature slots past IN_WIDTH read as zero so out-of-range map entries
   // contribute nothing to the table address.
   for (genvar j = 0; j < 2**IW; j++) begin : g_feat
      if (j < IN_WIDTH) begin : g_in
         assign feat[j] = in_reg[j*IN_BITS +: IN_BITS];
      end else begin : g_pad
         assign feat[j] = '0;
      end
   end

   for (genvar k = 0; k < FANIN; k++) begin : g_addr
      assign addr[k*IN_BITS +: IN_BITS] = feat[fmap[idx][k]];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.s_valid) state_nx = RUN;
         RUN:     if (idx == NW'(NEURONS-1)) state_nx = DRAIN;
         DRAIN:   state_nx = DONE;
         DONE:    if (bus.m_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      idle          = (state == IDLE) && !rst;
      bus.s_ready   = idle;
      bus.cfg_ready = idle;
      bus.m_valid   = (state == DONE) && !rst;
      rd_en         = (state == RUN);
   end

   assign accept = idle & bus.s_valid;
   assign cfg_ok = idle & bus.cfg_we;

   // Result of the read issued last cycle lands in slot idx_d; DRAIN
   // exists only to catch the final neuron's result.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         idx_d      <= '0;
         rd_vld     <= 1'b0;
         in_reg     <= '0;
         bus.m_data <= '0;
      end else begin
         rd_vld <= rd_en;
         idx_d  <= idx;
         if (accept) begin
            in_reg <= bus.s_data;
            idx    <= '0;
         end else if (rd_en) begin
            idx <= idx + 1'b1;
         end
         if (rd_vld) bus.m_data[idx_d*OUT_BITS +: OUT_BITS] <= rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NEURONS; n++)
            for (int k = 0; k < FANIN; k++)
               fmap[n][k] <= '0;
      end else if (cfg_ok && bus.cfg_sel) begin
         fmap[bus.cfg_addr[KW +: NW]][bus.cfg_addr[KW-1:0]] <= bus.cfg_wdata[IW-1:0];
      end
   end

   // Writes only happen in IDLE and reads only in RUN, so ports never collide.
   always_ff @(posedge clk) begin
      if (cfg_ok && !bus.cfg_sel) tbl[bus.cfg_addr] <= bus.cfg_wdata[OUT_BITS-1:0];
      if (rd_en) rd_data <= tbl[{idx, addr}];
   end
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer with a frame-level reference model.
module tb_lut_layer_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lut_layer_sequencer_if bus ();
   lut_layer_sequencer_if #(.IN_WIDTH(24)) bus2 ();

   lut_layer_sequencer u_dut  (.clk(clk), .rst(rst), .bus(bus));
   lut_layer_sequencer #(.IN_WIDTH(24)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference state: what the config port has committed, plus frame status.
   logic [1:0]  tbl_m [16][256];
   logic [4:0]  map_m [16][4];
   int          ncyc = 0;
   int          acc_n = 0;
   bit          pending = 0;
   bit          mv_exp;
   logic [31:0] exp_q;

   function automatic logic [31:0] model(input logic [63:0] d);
      logic [31:0] r;
      logic [1:0]  v;
      int          a;
      int          f;
      r = '0;
      for (int n = 0; n < 16; n++) begin
         a = 0;
         for (int k = 0; k < 4; k++) begin
            f = int'(map_m[n][k]);
            v = (f < 32) ? d[f*2 +: 2] : 2'b00;
            a = a + (int'(v) << (2*k));
         end
         r[n*2 +: 2] = tbl_m[n][a];
      end
      return r;
   endfunction

   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         chk("rst_s_ready", bus.s_ready, 1'b0);
         chk("rst_cfg_ready", bus.cfg_ready, 1'b0);
         chk("rst_m_valid", bus.m_valid, 1'b0);
         pending = 0;
         for (int n = 0; n < 16; n++)
            for (int k = 0; k < 4; k++)
               map_m[n][k] = '0;
      end else begin
         mv_exp = pending && (ncyc - acc_n >= 18);
         chk("s_ready", bus.s_ready, !pending);
         chk("cfg_ready", bus.cfg_ready, !pending);
         chk("m_valid", bus.m_valid, mv_exp);
         if (mv_exp) chk("m_data", bus.m_data, exp_q);
         if (!pending && bus.cfg_we) begin
            if (bus.cfg_sel) map_m[bus.cfg_addr[5:2]][bus.cfg_addr[1:0]] = bus.cfg_wdata;
            else             tbl_m[bus.cfg_addr[11:8]][bus.cfg_addr[7:0]] = bus.cfg_wdata[1:0];
         end
         if (!pending && bus.s_valid) begin
            pending = 1;
            acc_n   = ncyc;
            exp_q   = model(bus.s_data);
         end else if (mv_exp && bus.m_ready) begin
            pending = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input bit sel, input logic [11:0] a, input logic [4:0] d);
      bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_addr = a; bus.cfg_wdata = d;
      step();
      bus.cfg_we = 1'b0;
   endtask

   task automatic cfg_wr2(input bit sel, input logic [11:0] a, input logic [4:0] d);
      bus2.cfg_we = 1'b1; bus2.cfg_sel = sel; bus2.cfg_addr = a; bus2.cfg_wdata = d;
      step();
      bus2.cfg_we = 1'b0;
   endtask

   task automatic send(input logic [63:0] d);
      bit ok;
      ok = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.s_ready;
      end
      chk("send_accepted", ok, 1'b1);
      step();
      bus.s_valid = 1'b0;
      bus.cfg_we  = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.m_valid && n < 100);
      chk("m_valid_seen", bus.m_valid, 1'b1);
   endtask

   logic [63:0] vec;
   int          lat;

   initial begin
      rst = 1'b1;
      bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 1; bus.cfg_we = 0;
      bus.cfg_sel = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
      bus2.s_valid = 0; bus2.s_data = '0; bus2.m_ready = 1; bus2.cfg_we = 0;
      bus2.cfg_sel = 0; bus2.cfg_addr = '0; bus2.cfg_wdata = '0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_m_data", bus.m_data, 32'h0);
      chk("reset_m_valid", bus.m_valid, 1'b0);
      chk("reset_s_ready", bus.s_ready, 1'b1);
      step();

      // table[n][a] = a[1:0] ^ n[1:0], map[n][k] = (n+k) % 32
      for (int n = 0; n < 16; n++)
         for (int a = 0; a < 256; a++)
            cfg_wr(1'b0, 12'(n*256 + a), 5'((a ^ n) & 3));
      for (int n = 0; n < 16; n++)
         for (int k = 0; k < 4; k++)
            cfg_wr(1'b1, 12'(n*4 + k), 5'((n + k) % 32));

      // feature j = (3j+1)&3 -> every neuron yields 1
      for (int j = 0; j < 32; j++) vec[j*2 +: 2] = 2'((3*j + 1) & 3);
      send(vec);
      wait_valid(lat);
      chk("latency", lat, 18);
      chk("func_a", bus.m_data, 32'h5555_5555);
      step();

      // Backpressure: feature j = ~j -> every neuron yields 3
      bus.m_ready = 1'b0;
      for (int j = 0; j < 32; j++) vec[j*2 +: 2] = 2'(~j & 3);
      send(vec);
      wait_valid(lat);
      chk("bp_data0", bus.m_data, 32'hFFFF_FFFF);
      step();
      bus.s_valid = 1'b1;
      bus.s_data  = {$urandom, $urandom};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_data", bus.m_data, 32'hFFFF_FFFF);
         chk("bp_s_ready", bus.s_ready, 1'b0);
         step();
      end
      bus.m_ready = 1'b1;
      send(bus.s_data);
      wait_valid(lat);
      step();

      // Dropped config: write during RUN must not land
      send(64'h0);
      repeat (2) step();
      bus.cfg_we = 1; bus.cfg_sel = 0; bus.cfg_addr = 12'h300; bus.cfg_wdata = 5'd1;
      @(negedge clk);
      chk("drop_cfg_ready", bus.cfg_ready, 1'b0);
      step();
      bus.cfg_we = 0;
      wait_valid(lat);
      chk("drop_cur", bus.m_data, 32'hE4E4_E4E4);
      step();
      send(64'h0);
      wait_valid(lat);
      chk("drop_next_slot3", bus.m_data[7:6], 2'b11);
      step();

      // Reset at idx = 7
      send({$urandom, $urandom});
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", bus.s_ready, 1'b1);
      chk("post_rst_m_valid", bus.m_valid, 1'b0);
      step();
      // Maps are now all zero: neuron n sees feature 0 four times
      vec = {$urandom, $urandom};
      vec[1:0] = 2'b10;
      send(vec);
      wait_valid(lat);
      chk("post_rst_func", bus.m_data, 32'h4E4E_4E4E);
      step();

      // Same-cycle config write and accept
      bus.cfg_we = 1; bus.cfg_sel = 0; bus.cfg_addr = 12'h000; bus.cfg_wdata = 5'd3;
      send(64'h0);
      wait_valid(lat);
      chk("same_cycle_slot0", bus.m_data[1:0], 2'b11);
      chk("same_cycle_all", bus.m_data, 32'hE4E4_E4E7);
      step();

      // Map range on the IN_WIDTH = 24 instance
      cfg_wr2(1'b1, 12'h000, 5'd30);
      cfg_wr2(1'b0, 12'h0FC, 5'd1);
      cfg_wr2(1'b0, 12'h0FF, 5'd2);
      bus2.s_valid = 1'b1;
      bus2.s_data  = '1;
      @(negedge clk);
      chk("range_s_ready", bus2.s_ready, 1'b1);
      step();
      bus2.s_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus2.m_valid && lat < 100);
      chk("range_m_valid", bus2.m_valid, 1'b1);
      chk("range_slot0", bus2.m_data[1:0], 2'b01);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
